// File: rtl/tmds_rst_pkg.sv
// Shared types and default timing for the TMDS PLL reset sequencer.
// TMDS_PLL_RETRY_EN enables the lock-timeout PLL re-pulse path.
package tmds_rst_pkg;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_PLL_RST_CYC      = 64;
  localparam int DEF_LOCK_TIMEOUT_CYC = 500000;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_STEP_CYC         = 16;
  localparam int RETRY_W              = 8;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    REL_DIV,
    REL_SER,
    RUN
  } state_t;

  typedef struct packed {
    logic pll_rst;
    logic clkdiv_rst;
    logic oser_rst;
    logic pix_rst_n;
    logic ready;
  } rst_out_t;

  localparam rst_out_t RST_OUT = '{
    pll_rst:    1'b1,
    clkdiv_rst: 1'b1,
    oser_rst:   1'b1,
    pix_rst_n:  1'b0,
    ready:      1'b0
  };

  function automatic rst_out_t outs_of(input state_t s);
    rst_out_t o;
    o = RST_OUT;
    case (s)
      WAIT_LOCK: o.pll_rst = 1'b0;
      STABLE:    o.pll_rst = 1'b0;
      REL_DIV: begin
        o.pll_rst    = 1'b0;
        o.clkdiv_rst = 1'b0;
      end
      REL_SER: begin
        o.pll_rst    = 1'b0;
        o.clkdiv_rst = 1'b0;
        o.oser_rst   = 1'b0;
      end
      RUN: begin
        o.pll_rst    = 1'b0;
        o.clkdiv_rst = 1'b0;
        o.oser_rst   = 1'b0;
        o.pix_rst_n  = 1'b1;
        o.ready      = 1'b1;
      end
      default: o = RST_OUT;
    endcase
    return o;
  endfunction

  function automatic int max4(input int a, input int b,
                              input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/tmds_rst_seq_lock_sync.sv
// Multi-flop synchronizer bringing the asynchronous PLL lock into clk.
// Clears to 0 on reset so a stale lock is never trusted.
module lock_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/tmds_rst_seq.sv
// TMDS PLL reset sequencer: PLL reset, lock qualify, ordered releases.
// Define TMDS_PLL_RETRY_EN to re-pulse the PLL on lock timeout.
module tmds_rst_seq
  import tmds_rst_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int PLL_RST_CYC      = DEF_PLL_RST_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int STEP_CYC         = DEF_STEP_CYC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_rst,
  output logic               clkdiv_rst,
  output logic               oser_rst,
  output logic               pix_rst_n,
  output logic               ready,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int MAX_CYC = max4(PLL_RST_CYC, LOCK_TIMEOUT_CYC,
                                LOCK_STABLE_CYC, STEP_CYC);
  localparam int CW = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PLL_END  = CW'(PLL_RST_CYC - 1);
  localparam logic [CW-1:0] STB_END  = CW'(LOCK_STABLE_CYC - 1);
  localparam logic [CW-1:0] STEP_END = CW'(STEP_CYC - 1);

  logic          w_lock_s;
  logic          w_hold;
  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  rst_out_t      r_out;

  lock_sync #(
    .STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(pll_lock),
    .o_sync (w_lock_s)
  );

`ifdef TMDS_PLL_RETRY_EN
  localparam logic [CW-1:0] TO_END = CW'(LOCK_TIMEOUT_CYC - 1);
  logic w_timeout;
`endif

  always_comb begin
    w_nxt = r_state;
`ifdef TMDS_PLL_RETRY_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      PLL_RST: begin
        if (r_cnt == PLL_END) w_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (w_lock_s) begin
          w_nxt = STABLE;
`ifdef TMDS_PLL_RETRY_EN
        end else if (r_cnt == TO_END) begin
          w_nxt     = PLL_RST;
          w_timeout = 1'b1;
`endif
        end
      end
      STABLE: begin
        if (!w_lock_s)              w_nxt = WAIT_LOCK;
        else if (r_cnt == STB_END)  w_nxt = REL_DIV;
      end
      REL_DIV: begin
        if (!w_lock_s)              w_nxt = WAIT_LOCK;
        else if (r_cnt == STEP_END) w_nxt = REL_SER;
      end
      REL_SER: begin
        if (!w_lock_s)              w_nxt = WAIT_LOCK;
        else if (r_cnt == STEP_END) w_nxt = RUN;
      end
      RUN: begin
        if (!w_lock_s)              w_nxt = WAIT_LOCK;
      end
      default: w_nxt = PLL_RST;
    endcase
  end

  // Freeze the counter where no exit depends on it, so it never wraps.
`ifdef TMDS_PLL_RETRY_EN
  assign w_hold = (r_state == RUN);
`else
  assign w_hold = (r_state == RUN) || (r_state == WAIT_LOCK);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= PLL_RST;
      r_cnt   <= '0;
      r_out   <= RST_OUT;
    end else begin
      r_state <= w_nxt;
      r_out   <= outs_of(w_nxt);
      if (w_nxt != r_state) begin
        r_cnt <= '0;
      end else if (!w_hold) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

`ifdef TMDS_PLL_RETRY_EN
  logic [RETRY_W-1:0] r_retry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (w_timeout && (r_retry != '1)) begin
      r_retry <= r_retry + RETRY_W'(1);
    end
  end

  assign retry_cnt = r_retry;
`else
  assign retry_cnt = '0;
`endif

  assign pll_rst    = r_out.pll_rst;
  assign clkdiv_rst = r_out.clkdiv_rst;
  assign oser_rst   = r_out.oser_rst;
  assign pix_rst_n  = r_out.pix_rst_n;
  assign ready      = r_out.ready;

endmodule

// File: doc/tmds_rst_seq.md
Name: tmds_rst_seq

Overview:
- Reset sequencer that sits directly downstream of the TMDS PLL.
- Drives the PLL reset and watches its asynchronous lock output. Once lock has been stable long enough, it releases the CLKDIV reset, then the OSER10 serializer resets, then the pixel-domain reset, in that order.
- Any lock loss collapses all downstream resets. A lock timeout re-pulses the PLL reset.
- Runs on the free-running 50 MHz board clock that also feeds the PLL input.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the pll_lock synchronizer (minimum 2).
- PLL_RST_CYC, 64: clk cycles pll_rst is held high per pulse.
- LOCK_TIMEOUT_CYC, 500000: cycles to wait for lock before re-pulsing the PLL reset (10 ms at 50 MHz).
- LOCK_STABLE_CYC, 1024: consecutive synchronized-high lock cycles required before release.
- STEP_CYC, 16: cycles between successive reset releases.

Ports:
- clk  in  1: free-running 50 MHz reference clock.
- rst_n  in  1: asynchronous, active-low reset.
- pll_lock  in  1: PLL lock; asynchronous to clk.
- pll_rst  out  1: active-high reset to the PLL.
- clkdiv_rst  out  1: active-high reset to CLKDIV.
- oser_rst  out  1: active-high reset to the OSER10 serializers.
- pix_rst_n  out  1: active-low pixel-domain reset (consumer re-synchronizes it).
- ready  out  1: high only in RUN.
- retry_cnt  out  8: count of lock timeouts, saturating.

Behaviour:
- Reset values: pll_rst=1, clkdiv_rst=1, oser_rst=1, pix_rst_n=0, ready=0, retry_cnt=0, state=PLL_RST, cycle counter=0.
- All outputs are registered and are a pure function of state (Moore), plus retry_cnt.
- lock_s is pll_lock after SYNC_STAGES flip-flops.
- The cycle counter clears on every state entry. "N cycles" means the state is occupied for exactly N clk cycles.
- States:
  - PLL_RST: pll_rst=1. After PLL_RST_CYC cycles go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0, all downstream resets asserted.
    - lock_s=1: go to STABLE.
    - Counter reaches LOCK_TIMEOUT_CYC with lock_s=0: go to PLL_RST and increment retry_cnt (saturates at 255).
  - STABLE: counts consecutive cycles with lock_s=1.
    - lock_s=0: back to WAIT_LOCK with a fresh timeout.
    - LOCK_STABLE_CYC cycles reached: go to REL_DIV.
  - REL_DIV: clkdiv_rst=0. After STEP_CYC cycles go to REL_SER.
  - REL_SER: clkdiv_rst=0, oser_rst=0. After STEP_CYC cycles go to RUN.
  - RUN: clkdiv_rst=0, oser_rst=0, pix_rst_n=1, ready=1. Stays until lock loss.
- Lock loss (lock_s=0 in REL_DIV, REL_SER or RUN): next state is WAIT_LOCK.
  - All downstream resets reassert and ready drops on the same edge.
  - Total latency from the pll_lock fall to the outputs is SYNC_STAGES+1 clk cycles.
  - pll_rst is not pulsed on lock loss; the timeout path handles a PLL that does not recover.
- Reset ordering is guaranteed: release order is clkdiv, then oser, then pix. Assertion is simultaneous. pix_rst_n never goes high while oser_rst=1.
- A lock glitch shorter than 1 clk may or may not be captured. Once lock_s shows a loss, it is always honoured.
- rst_n asserted mid-sequence forces the reset values immediately (asynchronously).
- Counter width is $clog2 of the largest timing parameter plus 1. No wrap is possible, because every count terminates on equality.

Optional Feature:
- Macro: TMDS_PLL_RETRY_EN.
- Defined: timeout and retry behave as described above.
- Undefined:
  - The timeout comparison is removed and WAIT_LOCK waits indefinitely.
  - pll_rst pulses only once after rst_n.
  - The retry_cnt port remains, tied to 0.

Decomposition:
- Package tmds_rst_pkg holds:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, REL_DIV, REL_SER, RUN;
  - default timing constants;
  - retry_cnt width (8).
- One sub-module, lock_sync: parameterized SYNC_STAGES flip-flop synchronizer with async active-low reset clearing it to 0.

Test Plan:
Use SYNC_STAGES=2, PLL_RST_CYC=4, LOCK_TIMEOUT_CYC=100, LOCK_STABLE_CYC=8, STEP_CYC=4.
1. Clean bring-up: rst_n release, pll_lock rises 10 cycles later and stays high.
   - pll_rst is high for exactly 4 cycles.
   - clkdiv_rst falls 2+8 cycles after lock_s entry.
   - oser_rst falls 4 cycles later; pix_rst_n and ready rise 4 cycles after that.
   - retry_cnt stays 0.
2. Lock chatter: pll_lock high 5 cycles, low 3, then high.
   - STABLE aborts, no reset is released early, and the sequence completes 8 stable cycles after the final rise.
3. Lock loss in RUN: drop pll_lock.
   - clkdiv_rst, oser_rst, pix_rst_n and ready all change on the same edge, 3 cycles after the fall.
   - pll_rst stays 0.
4. Timeout: pll_lock held low.
   - pll_rst re-pulses every 104 cycles.
   - retry_cnt increments by 1 per pulse and holds at 255 after 255 pulses.
   - Without the macro: a single pulse and retry_cnt=0.
5. rst_n asserted during REL_SER: all outputs return to reset values without waiting for clk, and the sequence restarts from PLL_RST.
6. Ordering assertion throughout random lock waveforms: pix_rst_n=1 implies oser_rst=0, and oser_rst=0 implies clkdiv_rst=0.
